// File: rtl/lidar_frame_parser.sv
// lidar_frame_parser: byte-stream parser for LiDAR scan frames
//   0x55 0xAA, CT, FSA(16), LSA(16), [CS(16)], CT x 16-bit samples (little-endian).
// Emits per-frame min/max nonzero distance with the matching angle, a near-obstacle
// bitmap for the first ALERT_N samples, and error pulses for bad CT or an inter-byte
// timeout. Optional frame checksum: define LIDAR_CHECKSUM_EN.
module lidar_frame_parser #(
  parameter int MAX_CT       = 128,
  parameter int ALERT_N      = 16,
  parameter int ALERT_THRESH = 102,
  parameter int TIMEOUT_CYC  = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [1:0]         err_code,
  output logic [7:0]         ct,
  output logic [15:0]        fsa,
  output logic [15:0]        lsa,
  output logic [ALERT_N-1:0] obs_alert,
  output logic [15:0]        min_dist,
  output logic [15:0]        max_dist,
  output logic [15:0]        min_angle,
  output logic [15:0]        max_angle,
  output logic               busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, HDR1, CT, FSA_L, FSA_H, LSA_L, LSA_H,
`ifdef LIDAR_CHECKSUM_EN
    CS_L, CS_H,
`endif
    SMP_L, SMP_H, FINISH
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         lo_reg;          // low byte of the 16-bit word in flight
  logic [7:0]         ct_reg;
  logic [2:0]         k_reg;           // log2(CT)
  logic [15:0]        fsa_reg, lsa_reg;
  logic [7:0]         idx_reg;
  logic [15:0]        min_reg, max_reg;
  logic [7:0]         min_idx_reg, max_idx_reg;
  logic               any_reg;         // at least one nonzero sample seen
  logic [ALERT_N-1:0] alert_reg;
  logic [TW-1:0]      tmo_reg;
  logic               pend_reg;        // FINISH happened last cycle: publish now
  logic               pend_ok_reg;     // checksum verdict captured in FINISH

  logic [15:0]        word;
  logic               ct_ok, timed, tmo_hit, cs_ok, near;
  logic [2:0]         ct_log2;
  logic [15:0]        step, min_ang, max_ang;
  logic [ALERT_N-1:0] idx_hit;

  assign word    = {in_byte, lo_reg};
  assign ct_ok   = (in_byte != 8'd0) && (32'(in_byte) <= MAX_CT) &&
                   ((in_byte & (in_byte - 8'd1)) == 8'd0);
  assign timed   = (state_reg != IDLE) && (state_reg != FINISH);
  assign tmo_hit = timed && !in_valid && (tmo_reg == TW'(TIMEOUT_CYC - 1));
  assign busy    = (state_reg != IDLE);
  assign near    = (word != 16'd0) && (32'(word) < ALERT_THRESH);
  // Angle interpolation; only the low 16 bits matter so the sweep may wrap through 0.
  assign step    = (lsa_reg - fsa_reg) >> k_reg;
  assign min_ang = fsa_reg + 16'(min_idx_reg) * step;
  assign max_ang = fsa_reg + 16'(max_idx_reg) * step;

  // One-hot decode of the current sample index onto the alert bitmap.
  generate
    for (genvar gi = 0; gi < ALERT_N; gi++) begin : g_idx_hit
      assign idx_hit[gi] = (32'(idx_reg) == gi);
    end
  endgenerate

  // CT is known to be a power of two when used, so the highest set bit is log2(CT).
  always_comb begin
    ct_log2 = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in_byte[i]) ct_log2 = 3'(i);
    end
  end

`ifdef LIDAR_CHECKSUM_EN
  logic [15:0] cs_acc_reg, cs_rx_reg;
  assign cs_ok = (cs_acc_reg == cs_rx_reg);
`else
  assign cs_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: every state but FINISH moves only on an accepted byte.
  always_comb begin
    state_next = state_reg;
    if (tmo_hit) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, FINISH: state_next = (in_valid && in_byte == 8'h55) ? HDR1 : IDLE;
        HDR1:  if (in_valid) state_next = (in_byte == 8'hAA) ? CT :
                                          (in_byte == 8'h55) ? HDR1 : IDLE;
        CT:    if (in_valid) state_next = ct_ok ? FSA_L : IDLE;
        FSA_L: if (in_valid) state_next = FSA_H;
        FSA_H: if (in_valid) state_next = LSA_L;
        LSA_L: if (in_valid) state_next = LSA_H;
`ifdef LIDAR_CHECKSUM_EN
        LSA_H: if (in_valid) state_next = CS_L;
        CS_L:  if (in_valid) state_next = CS_H;
        CS_H:  if (in_valid) state_next = SMP_L;
`else
        LSA_H: if (in_valid) state_next = SMP_L;
`endif
        SMP_L: if (in_valid) state_next = SMP_H;
        SMP_H: if (in_valid) state_next = (idx_reg == ct_reg - 8'd1) ? FINISH : SMP_L;
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame accumulation: header fields, running statistics, timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_reg <= '0; ct_reg <= '0; k_reg <= '0; fsa_reg <= '0; lsa_reg <= '0;
      idx_reg <= '0; min_reg <= 16'hFFFF; max_reg <= '0;
      min_idx_reg <= '0; max_idx_reg <= '0; any_reg <= 1'b0; alert_reg <= '0;
      tmo_reg <= '0; pend_reg <= 1'b0; pend_ok_reg <= 1'b0;
`ifdef LIDAR_CHECKSUM_EN
      cs_acc_reg <= '0; cs_rx_reg <= '0;
`endif
    end else begin
      pend_reg    <= (state_reg == FINISH);
      pend_ok_reg <= cs_ok;
      if (!timed || in_valid) tmo_reg <= '0;
      else                    tmo_reg <= tmo_reg + TW'(1);
      if (in_valid) begin
        case (state_reg)
          CT: if (ct_ok) begin
            ct_reg <= in_byte; k_reg <= ct_log2; idx_reg <= '0;
            min_reg <= 16'hFFFF; max_reg <= '0; min_idx_reg <= '0; max_idx_reg <= '0;
            any_reg <= 1'b0; alert_reg <= '0;
`ifdef LIDAR_CHECKSUM_EN
            cs_acc_reg <= 16'hAA55 ^ {8'h00, in_byte};
`endif
          end
          FSA_L, LSA_L, SMP_L: lo_reg <= in_byte;
          FSA_H: begin
            fsa_reg <= word;
`ifdef LIDAR_CHECKSUM_EN
            cs_acc_reg <= cs_acc_reg ^ word;
`endif
          end
          LSA_H: begin
            lsa_reg <= word;
`ifdef LIDAR_CHECKSUM_EN
            cs_acc_reg <= cs_acc_reg ^ word;
`endif
          end
`ifdef LIDAR_CHECKSUM_EN
          CS_L: lo_reg <= in_byte;
          CS_H: cs_rx_reg <= word;
`endif
          SMP_H: begin
            idx_reg <= idx_reg + 8'd1;
`ifdef LIDAR_CHECKSUM_EN
            cs_acc_reg <= cs_acc_reg ^ word;
`endif
            // Zero means "no return"; strict compares keep the earliest index on ties.
            if (word != 16'd0) begin
              any_reg <= 1'b1;
              if (!any_reg || word < min_reg) begin min_reg <= word; min_idx_reg <= idx_reg; end
              if (!any_reg || word > max_reg) begin max_reg <= word; max_idx_reg <= idx_reg; end
            end
            if (near) alert_reg <= alert_reg | idx_hit;
          end
          default: ;
        endcase
      end
    end
  end

  // Result publication and error pulses; results change only on a good frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0; frame_err <= 1'b0; err_code <= '0;
      ct <= '0; fsa <= '0; lsa <= '0; obs_alert <= '0;
      min_dist <= '0; max_dist <= '0; min_angle <= '0; max_angle <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (state_reg == CT && in_valid && !ct_ok) begin
        frame_err <= 1'b1; err_code <= 2'd0;
      end else if (tmo_hit) begin
        frame_err <= 1'b1; err_code <= 2'd1;
      end else if (pend_reg && !pend_ok_reg) begin
        frame_err <= 1'b1; err_code <= 2'd2;
      end else if (pend_reg) begin
        frame_valid <= 1'b1;
        ct          <= ct_reg;
        fsa         <= fsa_reg;
        lsa         <= lsa_reg;
        obs_alert   <= alert_reg;
        min_dist    <= any_reg ? min_reg : 16'd0;
        max_dist    <= any_reg ? max_reg : 16'd0;
        min_angle   <= any_reg ? min_ang : fsa_reg;
        max_angle   <= any_reg ? max_ang : fsa_reg;
      end
    end
  end
endmodule
